ds3502_i2c_target: RTL



---
 rtl/ds3502_i2c_target_pkg.sv | 27 ++
 rtl/i2c_sync_edge.sv | 33 +++
 rtl/ds3502_i2c_target.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/ds3502_i2c_target_pkg.sv
// ds3502_i2c_target shared types and constants.
// FSM encoding, default target address and pad polarity.
package ds3502_i2c_target_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV,
    ST_DEV_ACK,
    ST_REG,
    ST_REG_ACK,
    ST_WR,
    ST_WR_ACK,
    ST_RD,
    ST_RD_ACK,
    ST_IGNORE
  } state_t;

  localparam logic [6:0] DEV_ADDR_DEF = 7'h28;
  localparam logic       IO_IN        = 1'b1;
  localparam logic       IO_OUT       = 1'b0;

  function automatic logic is_busy_st(input state_t s);
    return s inside {ST_DEV_ACK, ST_REG, ST_REG_ACK,
                     ST_WR, ST_WR_ACK, ST_RD, ST_RD_ACK};
  endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// Bus pin synchronizer with history flop and edge pulses.
// Level and edge outputs are aligned to the same clk cycle.
module i2c_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_pin,
  output logic o_lvl,
  output logic o_rise,
  output logic o_fall
);

  logic [2:0] r_sh;
  logic       r_rise;
  logic       r_fall;

  // Reset to 1: an idle I2C bus is pulled high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sh   <= 3'b111;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sh   <= {r_sh[1:0], i_pin};
      r_rise <= r_sh[1] & ~r_sh[2];
      r_fall <= ~r_sh[1] & r_sh[2];
    end
  end

  assign o_lvl  = r_sh[2];
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/ds3502_i2c_target.sv
// DS3502-style I2C target: address match, register pointer,
// burst writes with commit strobe and sequential reads.
module ds3502_i2c_target
  import ds3502_i2c_target_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEF,
  parameter int         REG_NUM  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 scl_i,
  input  logic                 sda_i,
  output logic                 sda_o,
  output logic                 sda_io_ctrl,
  output logic                 busy,
  output logic                 wr_stb,
  output logic [3:0]           wr_addr,
  output logic [7:0]           wr_data,
  output logic [8*REG_NUM-1:0] regs_flat
);

  localparam int PW = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;

  state_t r_state;
  state_t w_nxt;

  logic w_scl, w_scl_rise, w_scl_fall;
  logic w_sda, w_sda_rise, w_sda_fall;
  logic w_start, w_stop, w_done;
  logic w_drive, w_ptr_ok;

  logic [3:0]               r_cnt;
  logic [7:0]               r_shift;
  logic [PW-1:0]            r_ptr;
  logic [PW-1:0]            w_ptr_inc;
  logic [REG_NUM-1:0][7:0]  r_regs;
  logic                     r_mack;
  logic                     r_wr_stb;
  logic [3:0]               r_wr_addr;
  logic [7:0]               r_wr_data;

  i2c_sync_edge u_scl (
    .clk    (clk),
    .rst    (rst),
    .i_pin  (scl_i),
    .o_lvl  (w_scl),
    .o_rise (w_scl_rise),
    .o_fall (w_scl_fall)
  );

  i2c_sync_edge u_sda (
    .clk    (clk),
    .rst    (rst),
    .i_pin  (sda_i),
    .o_lvl  (w_sda),
    .o_rise (w_sda_rise),
    .o_fall (w_sda_fall)
  );

  assign w_start   = w_sda_fall & w_scl;
  assign w_stop    = w_sda_rise & w_scl;
  assign w_done    = w_scl_fall & (r_cnt == 4'd8);
  assign w_ptr_ok  = {24'd0, r_shift} < 32'(REG_NUM);
  assign w_ptr_inc = (32'(r_ptr) == 32'(REG_NUM - 1))
                   ? '0 : r_ptr + PW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (1'b1)
      w_start: w_nxt = ST_DEV;
      w_stop:  w_nxt = ST_IDLE;
      default: begin
        unique case (r_state)
          ST_DEV:
            if (w_done)
              w_nxt = (r_shift[7:1] == DEV_ADDR)
                    ? ST_DEV_ACK : ST_IGNORE;
          ST_DEV_ACK:
            if (w_scl_fall)
              w_nxt = r_shift[0] ? ST_RD : ST_REG;
          ST_REG:
            if (w_done)
              w_nxt = w_ptr_ok ? ST_REG_ACK : ST_IGNORE;
          ST_REG_ACK, ST_WR_ACK:
            if (w_scl_fall) w_nxt = ST_WR;
          ST_WR:
            if (w_done) w_nxt = ST_WR_ACK;
          ST_RD:
            if (w_done) w_nxt = ST_RD_ACK;
          ST_RD_ACK:
            if (w_scl_fall)
              w_nxt = r_mack ? ST_IGNORE : ST_RD;
          default: w_nxt = r_state;
        endcase
      end
    endcase
  end

  always_comb begin
    w_drive = 1'b0;
    unique case (r_state)
      ST_DEV_ACK, ST_REG_ACK, ST_WR_ACK: w_drive = 1'b1;
      ST_RD:   w_drive = ~r_shift[7];
      default: w_drive = 1'b0;
    endcase
  end

  // Drive follows the async-reset state, so reset releases SDA at once
  assign sda_o       = 1'b0;
  assign sda_io_ctrl = w_drive ? IO_OUT : IO_IN;
  assign busy        = is_busy_st(r_state) & ~w_start & ~w_stop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_shift   <= '0;
      r_ptr     <= '0;
      r_regs    <= '0;
      r_mack    <= 1'b0;
      r_wr_stb  <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_stb <= 1'b0;
      if (w_start || w_stop) begin
        r_cnt <= '0;
      end else if (w_scl_rise) begin
        if (r_state inside {ST_DEV, ST_REG, ST_WR, ST_RD})
          r_cnt <= r_cnt + 4'd1;
        if (r_state inside {ST_DEV, ST_REG, ST_WR})
          r_shift <= {r_shift[6:0], w_sda};
        if (r_state == ST_RD_ACK)
          r_mack <= w_sda;
      end else if (w_scl_fall) begin
        if (r_cnt == 4'd8) r_cnt <= '0;
        unique case (r_state)
          ST_DEV_ACK:
            if (r_shift[0]) r_shift <= r_regs[r_ptr];
          ST_REG:
            if (w_done && w_ptr_ok)
              r_ptr <= r_shift[PW-1:0];
          ST_WR:
            if (w_done) begin
              r_regs[r_ptr] <= r_shift;
              r_wr_stb      <= 1'b1;
              r_wr_addr     <= 4'(r_ptr);
              r_wr_data     <= r_shift;
              r_ptr         <= w_ptr_inc;
            end
          ST_RD:
            if (w_done) r_ptr <= w_ptr_inc;
            else        r_shift <= {r_shift[6:0], 1'b0};
          ST_RD_ACK:
            if (!r_mack) r_shift <= r_regs[r_ptr];
          default: ;
        endcase
      end
    end
  end

  assign wr_stb    = r_wr_stb;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign regs_flat = r_regs;

endmodule
